// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the iterative square-root controller:
//   - state_t         : controller FSM states (IDLE, CALC, DONE)
//   - RAD_W_DEFAULT   : default radicand width (even)
//   - ROOT_W_DEFAULT  : default root width (RAD_W_DEFAULT / 2)
//   - STEP_W          : width of the root-bit step index (8 root bits -> 3)
//   - STEP_MAX        : first step index under trial (most significant root bit)
// -----------------------------------------------------------------------------
package sqrt_pkg;

   localparam int RAD_W_DEFAULT  = 16;
   localparam int ROOT_W_DEFAULT = RAD_W_DEFAULT / 2;
   localparam int STEP_W         = 3;

   localparam logic [STEP_W-1:0] STEP_MAX = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : sqrt_pkg

// File: rtl/sqrt_trial_cmp.sv
// -----------------------------------------------------------------------------
// sqrt_trial_cmp
// Combinational trial/compare stage of the restoring square root.
// Sets the root bit under trial and reports whether the squared trial value
// still fits under the radicand.
//   root     in  ROOT_W  partial root built so far
//   step_idx in  STEP_W  root bit under trial
//   radicand in  RAD_W   latched operand
//   trial    out ROOT_W  root with bit step_idx set
//   accept   out 1       trial*trial <= radicand (full RAD_W-bit product)
// -----------------------------------------------------------------------------
module sqrt_trial_cmp
   import sqrt_pkg::*;
#(
   parameter int RAD_W  = RAD_W_DEFAULT,
   parameter int ROOT_W = ROOT_W_DEFAULT
) (
   input  logic [ROOT_W-1:0] root,
   input  logic [STEP_W-1:0] step_idx,
   input  logic [RAD_W-1:0]  radicand,
   output logic [ROOT_W-1:0] trial,
   output logic              accept
);

   logic [RAD_W-1:0] trial_ext;
   logic [RAD_W-1:0] square;

   assign trial     = root | (ROOT_W'(1) << step_idx);
   // Widen before multiplying: a ROOT_W-bit square needs the full RAD_W bits,
   // and 255*255 must not wrap.
   assign trial_ext = RAD_W'(trial);
   assign square    = trial_ext * trial_ext;
   assign accept    = (square <= radicand);

endmodule : sqrt_trial_cmp

// File: rtl/sqrt_iter_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_iter_ctrl
// Iterative floor(sqrt(radicand)) controller. One root bit is resolved per
// CALC cycle, MSB first; the step index and enable also drive a downstream
// 3-to-8 decoder.
//   clk       in  1       rising-edge clock
//   rst_n     in  1       asynchronous active-low reset
//   start     in  1       request a computation (sampled in IDLE only)
//   radicand  in  RAD_W   unsigned operand (latched on the accepting edge)
//   busy      out 1       computation in progress (CALC or DONE)
//   step_en   out 1       high in CALC only
//   step_idx  out 3       root bit under trial, 7..0; 0 when step_en=0
//   root      out ROOT_W  result, valid with done, held until next start
//   done      out 1       single-cycle result-valid pulse
// RAD_W must be even and ROOT_W must be 8 so the step index is 3 bits.
// -----------------------------------------------------------------------------
module sqrt_iter_ctrl
   import sqrt_pkg::*;
#(
   parameter int RAD_W  = RAD_W_DEFAULT,
   parameter int ROOT_W = ROOT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [RAD_W-1:0]  radicand,
   output logic              busy,
   output logic              step_en,
   output logic [STEP_W-1:0] step_idx,
   output logic [ROOT_W-1:0] root,
   output logic              done
);

   state_t             state_q;
   state_t             state_d;
   logic [STEP_W-1:0]  cnt_q;
   logic [RAD_W-1:0]   rad_q;
   logic [ROOT_W-1:0]  root_q;
   logic [ROOT_W-1:0]  trial;
   logic               accept;

   sqrt_trial_cmp #(
      .RAD_W  (RAD_W),
      .ROOT_W (ROOT_W)
   ) u_trial_cmp (
      .root     (root_q),
      .step_idx (cnt_q),
      .radicand (rad_q),
      .trial    (trial),
      .accept   (accept)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: next state is defaulted first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset as well because root, the step
   // counter and the latched radicand are all defined to read zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         rad_q  <= '0;
         root_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  rad_q  <= radicand;
                  root_q <= '0;
                  cnt_q  <= STEP_MAX;
               end
            end
            CALC: begin
               if (accept) root_q <= trial;
               // Counter parks at 0 on the last step; DONE/IDLE never read it.
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs come from registers or are decoded from the state register only.
   assign busy     = (state_q != IDLE);
   assign step_en  = (state_q == CALC);
   assign step_idx = step_en ? cnt_q : '0;
   assign root     = root_q;
   assign done     = (state_q == DONE);

endmodule : sqrt_iter_ctrl

// File: tb/tb_sqrt_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_iter_ctrl
// Directed self-checking bench for sqrt_iter_ctrl. Expected roots come from a
// brute-force integer square root and travel through a scoreboard queue from
// the point a start is driven to the point done is observed.
// -----------------------------------------------------------------------------
module tb_sqrt_iter_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] radicand;
   logic        busy;
   logic        step_en;
   logic [2:0]  step_idx;
   logic [7:0]  root;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb[$];

   sqrt_iter_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .radicand (radicand),
      .busy     (busy),
      .step_en  (step_en),
      .step_idx (step_idx),
      .root     (root),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] isqrt(input logic [15:0] x);
      int res = 0;
      for (int r = 0; r < 256; r++)
         if (r * r <= int'(x)) res = r;
      return 8'(res);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pop_and_check(input string tag);
      logic [7:0] exp_root;
      if (sb.size() == 0) begin
         check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         exp_root = sb.pop_front();
         check(tag, 32'(root), 32'(exp_root));
      end
   endtask

   // One full computation: start pulse, 8 CALC cycles, one DONE cycle, then
   // one IDLE cycle with root held. Optionally change radicand after acceptance.
   task automatic run_one(input string tag, input logic [15:0] rad,
                          input bit change, input logic [15:0] rad2);
      logic [7:0] held;
      @(negedge clk);
      start    = 1'b1;
      radicand = rad;
      sb.push_back(isqrt(rad));
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            if (change) radicand = rad2;
         end
         check({tag, "_step_en"}, 32'(step_en), 32'd1);
         check({tag, "_step_idx"}, 32'(step_idx), 32'(8 - k));
         check({tag, "_busy_calc"}, 32'(busy), 32'd1);
         check({tag, "_no_early_done"}, 32'(done), 32'd0);
      end
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      check({tag, "_step_en_done"}, 32'(step_en), 32'd0);
      check({tag, "_step_idx_done"}, 32'(step_idx), 32'd0);
      pop_and_check({tag, "_root"});
      held = root;
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      check({tag, "_root_held"}, 32'(root), 32'(held));
   endtask

   initial begin
      int n_done;
      int last_k;

      rst_n    = 1'b0;
      start    = 1'b0;
      radicand = '0;

      // Reset state
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_step_en", 32'(step_en), 32'd0);
      check("rst_step_idx", 32'(step_idx), 32'd0);
      check("rst_root", 32'(root), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Basic and boundary radicands
      run_one("r144", 16'd144, 1'b0, 16'd0);
      run_one("r143", 16'd143, 1'b0, 16'd0);
      run_one("r0", 16'd0, 1'b0, 16'd0);
      run_one("r65535", 16'd65535, 1'b0, 16'd0);
      run_one("r1", 16'd1, 1'b0, 16'd0);

      // Radicand changed one cycle after acceptance has no effect
      run_one("rchg", 16'd144, 1'b1, 16'd10000);

      // Start re-pulsed mid-CALC is ignored and not queued
      @(negedge clk);
      start    = 1'b1;
      radicand = 16'd144;
      sb.push_back(isqrt(16'd144));
      n_done = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = (k == 3);
         if (k == 3) radicand = 16'd400;
         if (k == 4) radicand = 16'd0;
         if (done) begin
            n_done++;
            check("ign_done_latency", 32'(k), 32'd9);
            pop_and_check("ign_root");
         end
      end
      check("ign_single_done", 32'(n_done), 32'd1);
      check("ign_sb_empty", 32'(sb.size()), 32'd0);

      // Start held high: back-to-back runs, done every 10 cycles
      @(negedge clk);
      start    = 1'b1;
      radicand = 16'd81;
      for (int i = 0; i < 3; i++) sb.push_back(isqrt(16'd81));
      n_done = 0;
      last_k = 0;
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         if (k == 21) start = 1'b0;
         if (done) begin
            n_done++;
            check("b2b_spacing", 32'(k - last_k), (n_done == 1) ? 32'd9 : 32'd10);
            last_k = k;
            pop_and_check("b2b_root");
         end
      end
      check("b2b_done_count", 32'(n_done), 32'd3);
      check("b2b_sb_empty", 32'(sb.size()), 32'd0);

      // Reset mid-CALC at step_idx=4 aborts with no done pulse
      @(negedge clk);
      start    = 1'b1;
      radicand = 16'd50000;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("abort_idx_before", 32'(step_idx), 32'd4);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_step_en", 32'(step_en), 32'd0);
      check("abort_step_idx", 32'(step_idx), 32'd0);
      check("abort_root", 32'(root), 32'd0);
      n_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
      run_one("r225", 16'd225, 1'b0, 16'd0);

      check("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sqrt_iter_ctrl
